// File: rtl/signature_tester.sv
// signature_tester: seeded LFSR stimulus generator and 16-bit MISR response
// compactor for an 8-bit circuit under test with a clear/input/output interface.
module signature_tester #(
    parameter int NUM_VECTORS  = 256,
    parameter int CLEAR_CYCLES = 2,
    parameter int PIPE_LAT     = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  seed,
    output logic        cct_clear,
    output logic [7:0]  cct_input,
    input  logic [7:0]  cct_output,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  CLR_LAST   = 4'(CLEAR_CYCLES - 1);
    localparam logic [15:0] RUN_LAST   = 16'(NUM_VECTORS - 1);
    localparam logic [2:0]  DRAIN_LAST = 3'(PIPE_LAT - 1);

    // Fibonacci LFSR step, x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // MISR step, x^16+x^15+x^13+x^4+1, folding in one 8-bit response
    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [7:0] d);
        return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {8'h00, d};
    endfunction

    state_t      state_r;
    logic [7:0]  lfsr_r;
    logic [15:0] misr_r;
    logic [3:0]  clr_cnt_r;
    logic [15:0] run_cnt_r;
    logic [2:0]  drain_cnt_r;
    logic        cct_clear_r;
    logic [7:0]  cct_input_r;
    logic        busy_r;
    logic        done_r;
    logic        compact_run_s;
    logic [7:0]  seed_eff_s;
    logic [7:0]  lfsr_next_s;

    // An all-zero seed would lock the LFSR, so substitute 8'h01
    assign seed_eff_s  = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_next_s = lfsr_step(lfsr_r);

    // RUN-phase compaction starts once the CUT pipeline has filled
    generate
        if (PIPE_LAT == 0) begin : g_comb
            assign compact_run_s = 1'b1;
        end else begin : g_pipe
            assign compact_run_s = (run_cnt_r >= 16'(PIPE_LAT));
        end
    endgenerate

    // Sequencer: run phases, stimulus LFSR, MISR and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            lfsr_r      <= 8'h01;
            misr_r      <= 16'h0000;
            clr_cnt_r   <= 4'd0;
            run_cnt_r   <= 16'd0;
            drain_cnt_r <= 3'd0;
            cct_clear_r <= 1'b0;
            cct_input_r <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lfsr_r      <= seed_eff_s;
                        cct_input_r <= seed_eff_s;
                        misr_r      <= 16'h0000;
                        clr_cnt_r   <= 4'd0;
                        run_cnt_r   <= 16'd0;
                        drain_cnt_r <= 3'd0;
                        cct_clear_r <= 1'b1;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        state_r     <= ST_CLEAR;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        cct_clear_r <= 1'b0;
                        state_r     <= ST_RUN;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + 4'd1;
                    end
                end
                ST_RUN: begin
                    lfsr_r      <= lfsr_next_s;
                    cct_input_r <= lfsr_next_s;
                    if (compact_run_s) begin
                        misr_r <= misr_step(misr_r, cct_output);
                    end else begin
                        misr_r <= misr_r;
                    end
                    if (run_cnt_r == RUN_LAST) begin
                        if (PIPE_LAT == 0) begin
                            cct_input_r <= 8'h00;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end else begin
                        run_cnt_r <= run_cnt_r + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    lfsr_r      <= lfsr_next_s;
                    cct_input_r <= lfsr_next_s;
                    misr_r      <= misr_step(misr_r, cct_output);
                    if (drain_cnt_r == DRAIN_LAST) begin
                        cct_input_r <= 8'h00;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 3'd1;
                    end
                end
                default: begin
                    cct_clear_r <= 1'b0;
                    cct_input_r <= 8'h00;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cct_clear = cct_clear_r;
    assign cct_input = cct_input_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign signature = misr_r;

endmodule

// File: tb/tb_signature_tester.sv
// tb_signature_tester: directed checks of signature_tester using several
// instances with different parameters and small hand-analysed CUTs.
module tb_signature_tester;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       start_c = 1'b0;
    logic [7:0] seed = 8'h01;

    int n_vec = 0;
    int n_fail = 0;

    // Instance A: pass-through CUT, NUM_VECTORS=1
    logic        clr_a, busy_a, done_a;
    logic [7:0]  in_a;
    logic [15:0] sig_a;
    signature_tester #(.NUM_VECTORS(1), .CLEAR_CYCLES(2), .PIPE_LAT(0)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
        .cct_clear(clr_a), .cct_input(in_a), .cct_output(in_a),
        .busy(busy_a), .done(done_a), .signature(sig_a));

    // Instance B: pass-through CUT, NUM_VECTORS=2
    logic        clr_b, busy_b, done_b;
    logic [7:0]  in_b;
    logic [15:0] sig_b;
    signature_tester #(.NUM_VECTORS(2), .CLEAR_CYCLES(2), .PIPE_LAT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
        .cct_clear(clr_b), .cct_input(in_b), .cct_output(in_b),
        .busy(busy_b), .done(done_b), .signature(sig_b));

    // Instance C: CUT tied to zero, default 256 vectors, separate start
    logic        clr_c, busy_c, done_c;
    logic [7:0]  in_c;
    logic [15:0] sig_c;
    signature_tester #(.NUM_VECTORS(256), .CLEAR_CYCLES(2), .PIPE_LAT(0)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .seed(seed),
        .cct_clear(clr_c), .cct_input(in_c), .cct_output(8'h00),
        .busy(busy_c), .done(done_c), .signature(sig_c));

    // Instance D: pass-through CUT with one register, PIPE_LAT=1
    logic        clr_d, busy_d, done_d;
    logic [7:0]  in_d, reg_d;
    logic [15:0] sig_d;
    signature_tester #(.NUM_VECTORS(2), .CLEAR_CYCLES(2), .PIPE_LAT(1)) u_d (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
        .cct_clear(clr_d), .cct_input(in_d), .cct_output(reg_d),
        .busy(busy_d), .done(done_d), .signature(sig_d));

    // Instance E: pass-through CUT, NUM_VECTORS=3
    logic        clr_e, busy_e, done_e;
    logic [7:0]  in_e;
    logic [15:0] sig_e;
    signature_tester #(.NUM_VECTORS(3), .CLEAR_CYCLES(2), .PIPE_LAT(0)) u_e (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
        .cct_clear(clr_e), .cct_input(in_e), .cct_output(in_e),
        .busy(busy_e), .done(done_e), .signature(sig_e));

    // One-stage pipelined CUT model for instance D
    always_ff @(posedge clk) begin
        reg_d <= in_d;
    end

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run instance C to completion, counting clear and busy cycles
    task automatic run_c(input string tag, input bit poke_start);
        int  n_clr;
        int  n_busy;
        bit  got;
        n_clr = 0;
        n_busy = 0;
        got = 1'b0;
        start_c = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            start_c = (poke_start && i == 50);
            if (clr_c) n_clr++;
            if (busy_c) n_busy++;
            if (done_c) begin
                got = 1'b1;
                break;
            end
        end
        start_c = 1'b0;
        check({tag, "_done_reached"}, {15'd0, got}, 16'd1);
        check({tag, "_clear_cycles"}, 16'(n_clr), 16'd2);
        check({tag, "_busy_cycles"}, 16'(n_busy), 16'd258);
        check({tag, "_sig"}, sig_c, 16'h0000);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_sig_a", sig_a, 16'h0000);
        check("rst_in_a", {8'h00, in_a}, 16'h0000);
        check("rst_flags_a", {13'd0, clr_a, busy_a, done_a}, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_flags_c", {13'd0, clr_c, busy_c, done_c}, 16'h0000);

        // Run 1: seed 8'h01
        seed = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_t1_flags_a", {13'd0, clr_a, busy_a, done_a}, 16'h0006);
        check("r1_t1_in_a", {8'h00, in_a}, 16'h0001);
        tick();
        check("r1_t2_clear_a", {15'd0, clr_a}, 16'd1);
        tick();
        check("r1_t3_flags_a", {13'd0, clr_a, busy_a, done_a}, 16'h0002);
        check("r1_t3_in_b", {8'h00, in_b}, 16'h0001);
        tick();
        check("r1_t4_done_a", {15'd0, done_a}, 16'd1);
        check("r1_sig_a", sig_a, 16'h0001);
        check("r1_t4_in_a_idle", {8'h00, in_a}, 16'h0000);
        check("r1_t4_in_b", {8'h00, in_b}, 16'h0002);
        check("r1_t4_done_b", {15'd0, done_b}, 16'd0);
        tick();
        check("r1_t5_done_b", {15'd0, done_b}, 16'd1);
        check("r1_sig_b", sig_b, 16'h0000);
        check("r1_t5_done_d", {15'd0, done_d}, 16'd0);
        tick();
        check("r1_t6_done_d", {15'd0, done_d}, 16'd1);
        check("r1_sig_d", sig_d, 16'h0000);

        // Run 2: seed 8'h00 from DONE, must match seed 8'h01
        seed = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_t1_done_a", {15'd0, done_a}, 16'd0);
        check("r2_t1_in_a", {8'h00, in_a}, 16'h0001);
        check("r2_t1_sig_a", sig_a, 16'h0000);
        for (int i = 0; i < 5; i++) tick();
        check("r2_sig_a", sig_a, 16'h0001);
        check("r2_sig_b", sig_b, 16'h0000);
        check("r2_sig_d", sig_d, 16'h0000);
        check("r2_done_d", {15'd0, done_d}, 16'd1);

        // Run 3: seed 8'hB8, vectors B8,70,E0
        seed = 8'hB8;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r3_t1_in_e", {8'h00, in_e}, 16'h00B8);
        tick();
        tick();
        tick();
        check("r3_t4_in_e", {8'h00, in_e}, 16'h0070);
        tick();
        check("r3_t5_in_e", {8'h00, in_e}, 16'h00E0);
        tick();
        check("r3_sig_a", sig_a, 16'h00B8);
        check("r3_sig_b", sig_b, 16'h0101);
        check("r3_sig_d", sig_d, 16'h0101);
        check("r3_sig_e", sig_e, 16'h02E2);
        check("r3_done_e", {15'd0, done_e}, 16'd1);

        // Long run with a start poke during busy that must be ignored
        seed = 8'h5A;
        run_c("c_long", 1'b1);

        // Abort mid-RUN with asynchronous reset
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("mid_busy_c", {15'd0, busy_c}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_in_c", {8'h00, in_c}, 16'h0000);
        check("arst_flags_c", {13'd0, clr_c, busy_c, done_c}, 16'h0000);
        check("arst_sig_a", sig_a, 16'h0000);
        check("arst_done_e", {15'd0, done_e}, 16'd0);
        #3;
        reset_n = 1'b1;
        tick();
        run_c("c_after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/signature_tester.md
Name: signature_tester

Overview:
- Self-contained stimulus generator and response compactor that drives an 8-bit circuit under test (CUT) with the clk/clear/cct_input/cct_output interface and signs its outputs.
- Generates seeded pseudo-random 8-bit vectors and an initial clear pulse.
- Compacts the CUT's 8-bit output into a 16-bit MISR signature, reported with a done flag.
- Replaces the behavioural bench driver so signatures can be produced in hardware, e.g. on the lab board.

Parameters:
- NUM_VECTORS, 256: number of RUN cycles (vectors applied and compacted); legal range 1..65535.
- CLEAR_CYCLES, 2: cycles cct_clear is held high before RUN; legal range 1..15.
- PIPE_LAT, 0: CUT output latency in clocks (0 = combinational CUT); legal range 0..7.

Ports:
- clk, input, 1: system clock; all state on rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to begin a run; sampled only in IDLE and DONE.
- seed, input, 8: LFSR seed, captured on the accepted start.
- cct_clear, output, 1: clear drive to the CUT.
- cct_input, output, 8: stimulus vector to the CUT.
- cct_output, input, 8: CUT response.
- busy, output, 1: high from the cycle after an accepted start until DONE is entered.
- done, output, 1: high in DONE; signature valid.
- signature, output, 16: MISR contents; holds its value in DONE.

Behaviour:
- Reset, asynchronous, any state:
  - state goes to IDLE.
  - Outputs: cct_clear=0, cct_input=8'h00, busy=0, done=0, signature=16'h0000.
  - lfsr=8'h01; all counters cleared.
- Stimulus LFSR (8-bit Fibonacci, x^8+x^6+x^5+x^4+1):
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - On the accepted start, lfsr loads seed; seed 8'h00 is replaced by 8'h01 so the LFSR never locks up.
  - cct_input = lfsr in CLEAR, RUN and DRAIN; 8'h00 in IDLE and DONE.
- MISR (16-bit, x^16+x^15+x^13+x^4+1):
  - fb = m[15]^m[14]^m[12]^m[3].
  - next m = {m[14:0], fb} ^ {8'h00, cct_output}.
  - Cleared to 0 on the accepted start.
  - The MISR register drives signature directly.
- States:
  - IDLE: start=1 loads seed and clears the MISR, then goes to CLEAR.
  - CLEAR: cct_clear=1 for exactly CLEAR_CYCLES cycles. lfsr holds, MISR holds, no compaction. Then goes to RUN.
  - RUN: cct_clear=0 for exactly NUM_VECTORS cycles. Each cycle at the rising edge: lfsr advances; the MISR compacts cct_output if the number of RUN cycles elapsed is >= PIPE_LAT. Then goes to DRAIN, or to DONE if PIPE_LAT=0.
  - DRAIN: lasts PIPE_LAT cycles. lfsr keeps advancing; cct_clear=0; the MISR compacts every cycle. Total compactions in a run is therefore always NUM_VECTORS. Then goes to DONE.
  - DONE: done=1, busy=0, signature held. start=1 behaves as in IDLE (restart, done drops next cycle).
- start outside IDLE or DONE is ignored. A run is not restarted mid-operation.
- Counters are sized for the parameter maxima; the RUN counter must not wrap at NUM_VECTORS=65535.
- reset_n asserted mid-run aborts immediately to reset values; a subsequent start gives the full run.

Test Plan:
- Pass-through CUT (cct_output=cct_input), PIPE_LAT=0, NUM_VECTORS=1, seed 8'h01 -> done after 1+2+1 cycles from start; signature=16'h0001.
- Same CUT, NUM_VECTORS=2, seed 8'h01 -> cct_input sequence 8'h01, 8'h02; signature=16'h0000.
- Seed 8'h00 with the above setup -> identical result to seed 8'h01 (lock-up substitution).
- CUT tied to 8'h00, NUM_VECTORS=256 -> signature=16'h0000; cct_clear high exactly 2 cycles after start; busy high for 258 cycles.
- Pass-through CUT with one added register, PIPE_LAT=1, NUM_VECTORS=2, seed 8'h01 -> signature=16'h0000 (matches the combinational case); done one cycle later.
- Reset and protocol checks:
  - reset_n pulsed low mid-RUN -> all outputs return to reset values asynchronously.
  - start pulsed during busy -> ignored.
  - start in DONE -> new run with the same signature for the same seed.
